// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter for 4 requesters with a bounded grant hold time.
// Outputs are registered; rotation is forced once a grant reaches MAX_HOLD.
module rr_hold_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    last_q;
  logic [1:0]    id_q;
  logic [3:0]    gnt_q;
  logic          busy_q;
  logic          to_q;

  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       win_vld;
  logic       at_max;

  // While granted, the owner is about to become LAST, so it is the base.
  assign base   = (state_q == GRANT) ? id_q : last_q;
  assign at_max = (cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!win_vld && REQ[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      id_q    <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            gnt_q   <= 4'b0001 << win;
            id_q    <= win;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (REQ[id_q] && !at_max) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            last_q <= id_q;
            cnt_q  <= '0;
            to_q   <= REQ[id_q];
            if (win_vld) begin
              gnt_q <= 4'b0001 << win;
              id_q  <= win;
            end else begin
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = id_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = to_q;

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter sharing one resource among 4 requesters.
- A grant is held while its requester keeps REQ high, up to MAX_HOLD cycles. On timeout the grant rotates to the next requester, so no requester can starve the others.
- Outputs are registered. GNT is one-hot, with an encoded owner ID, a BUSY flag and a one-cycle TIMEOUT pulse.
- Sits in front of the shared resource as the successor to the fixed-priority scheme: a fair, bounded-latency arbiter.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held. Legal range is 2..256.
- CW, 8, hold counter width. Must satisfy 2^CW >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- REQ  input  4  request lines, one per requester, level-sensitive
- GNT  output  4  registered one-hot grant; all zero when idle
- GNT_ID  output  2  binary index of the current owner; holds the last owner while idle
- BUSY  output  1  registered; equals OR of GNT
- TIMEOUT  output  1  one-cycle pulse, high in the first cycle after a hold-limit rotation

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset=0, outputs are forced immediately, independent of clk:
  - GNT=0000, GNT_ID=00, BUSY=0, TIMEOUT=0.
  - Internal state=IDLE, hold counter=0, last-owner pointer LAST=3, so requester 0 has top priority first.
  - Reset mid-grant drops GNT at once, with no completion cycle.
- Priority order: cyclic, starting at (LAST+1) mod 4. Example: LAST=1 gives 2>3>0>1.
- State IDLE:
  - Each edge, if REQ!=0, pick the first requesting index in priority order.
  - Load GNT=onehot(w), GNT_ID=w, counter=0, state=GRANT.
  - Latency: REQ sampled at edge k produces GNT visible after edge k. No combinational path from REQ to GNT.
  - If REQ=0, stay in IDLE with GNT=0.
- State GRANT, owner o, each edge:
  - (a) REQ[o]=1 and counter<MAX_HOLD-1: hold GNT, counter+1.
  - (b) REQ[o]=0 (release): set LAST=o. If other requests are pending, grant the next winner at this same edge (zero dead cycles, counter=0). Otherwise GNT=0 and state=IDLE.
  - (c) REQ[o]=1 and counter==MAX_HOLD-1 (timeout): set LAST=o and re-arbitrate with o at lowest priority. If o is the only requester, regrant o (GNT unchanged, counter=0). TIMEOUT=1 for the following cycle only.
- Guarantees:
  - A grant is visible at most MAX_HOLD consecutive cycles per arbitration.
  - A pending requester waits at most 3*MAX_HOLD+1 cycles.
- TIMEOUT is 0 in every cycle not directly following a timeout edge, including release transitions.
- Simultaneous owner release and new requests are covered by (b). Other REQ bits changing mid-grant do not disturb the owner.
- The counter never exceeds MAX_HOLD-1, and there is no wrap-around.
- GNT is always one-hot or zero, and GNT_ID is consistent with GNT whenever BUSY=1.

Test Plan:
- Reset then REQ=0110 → GNT=0010 one cycle later, GNT_ID=01. Drop REQ[1] → next edge GNT=0100, with no idle cycle.
- REQ=1111 held constantly with MAX_HOLD=8 → grants rotate 0001,0010,0100,1000,0001. Each grant lasts exactly 8 cycles, and TIMEOUT pulses once per rotation.
- Only REQ[3]=1 for 20 cycles → GNT=1000 throughout. TIMEOUT pulses at cycles 9 and 17, and GNT never glitches to 0.
- REQ=0001 for 3 cycles then 0000 → GNT=0001 for exactly 3 cycles, then 0000 and BUSY=0. GNT_ID stays 00 and LAST=0, so the next REQ=1001 grants 1000.
- Assert reset=0 asynchronously mid-grant, between clock edges → GNT=0000, BUSY=0, TIMEOUT=0 immediately. After release with REQ=1111, first grant is 0001.
- Random REQ for 10k cycles with checkers:
  - GNT is one-hot or zero, and BUSY equals OR of GNT.
  - No grant runs longer than MAX_HOLD cycles.
  - Every request is granted within 3*MAX_HOLD+1 cycles.
